// File: rtl/eth_mac_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the 1G MAC TX AXI-stream from S_COUNT sources.
// Optional mid-frame stall abort is enabled by defining ARB_TIMEOUT_EN.
module eth_mac_tx_arbiter #(
  parameter int S_COUNT = 2,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [S_COUNT*8-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]   s_axis_tvalid,
  output logic [S_COUNT-1:0]   s_axis_tready,
  input  logic [S_COUNT-1:0]   s_axis_tlast,
  input  logic [S_COUNT-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_index,
  output logic [15:0]          frame_count,
  output logic                 timeout_event
);

  if (S_COUNT < 2 || S_COUNT > 8 || IDX_W < $clog2(S_COUNT) ||
      TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
    $error("eth_mac_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_ABORT, ST_DROP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [IDX_W:0]   cand;
  logic [7:0]       src_data;
  logic             src_valid, src_last, src_user;
  logic             frame_done;
  logic             release_grant;
  logic             stall_hit;
  logic             abort_hs;

  always_comb begin
    src_data  = s_axis_tdata[grant_index*8 +: 8];
    src_valid = s_axis_tvalid[grant_index];
    src_last  = s_axis_tlast[grant_index];
    src_user  = s_axis_tuser[grant_index];
  end

  assign ptr_next = (grant_index == IDX_W'(S_COUNT - 1)) ? '0 : grant_index + IDX_W'(1);

  // Scan requesters starting at the round-robin pointer, wrapping modulo S_COUNT.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(S_COUNT))
        cand = cand - (IDX_W+1)'(S_COUNT);
      if (!arb_found && s_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == ST_PASS && !src_valid)
      stall_cnt <= stall_cnt + 16'd1;
    else
      stall_cnt <= '0;
  end

  assign stall_hit     = (stall_cnt == 16'(TIMEOUT - 1)) && !src_valid;
  assign timeout_event = abort_hs;
`else
  assign stall_hit     = 1'b0;
  assign timeout_event = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    frame_done    = 1'b0;
    release_grant = 1'b0;
    abort_hs      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_found)
          state_nxt = ST_PASS;
      end
      ST_PASS: begin
        m_axis_tdata               = src_data;
        m_axis_tvalid              = src_valid;
        m_axis_tlast               = src_last;
        m_axis_tuser               = src_user;
        s_axis_tready[grant_index] = m_axis_tready;
        if (src_valid && m_axis_tready && src_last) begin
          frame_done    = 1'b1;
          release_grant = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (stall_hit) begin
          state_nxt = ST_ABORT;
        end
      end
`ifdef ARB_TIMEOUT_EN
      ST_ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          abort_hs   = 1'b1;
          frame_done = 1'b1;
          state_nxt  = ST_DROP;
        end
      end
      ST_DROP: begin
        s_axis_tready[grant_index] = 1'b1;
        if (src_valid && src_last) begin
          release_grant = 1'b1;
          state_nxt     = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && arb_found) begin
        grant_index <= arb_idx;
        grant_valid <= 1'b1;
      end
      if (frame_done)
        frame_count <= frame_count + 16'd1;
      if (release_grant) begin
        ptr         <= ptr_next;
        grant_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_mac_tx_arbiter.sv
// Table-driven bench for eth_mac_tx_arbiter (S_COUNT=3), plus directed backpressure
// and, when ARB_TIMEOUT_EN is defined, stall-abort sequences.
module tb_eth_mac_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] s_axis_tdata;
  logic [2:0]  s_axis_tvalid;
  logic [2:0]  s_axis_tready;
  logic [2:0]  s_axis_tlast;
  logic [2:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        grant_valid;
  logic [2:0]  grant_index;
  logic [15:0] frame_count;
  logic        timeout_event;

  int n_chk  = 0;
  int n_pass = 0;

  eth_mac_tx_arbiter #(.S_COUNT(3), .IDX_W(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .grant_valid(grant_valid), .grant_index(grant_index),
    .frame_count(frame_count), .timeout_event(timeout_event)
  );

  always #5 clk = ~clk;

  // Expected layout: {m_valid, m_data, m_last, m_user, s_ready, grant_valid, grant_index, frame_count}
  typedef struct {
    logic        rst;
    logic [2:0]  v, l, u;
    logic [23:0] d;
    logic [33:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [2:0] v, input logic [2:0] l,
                              input logic [2:0] u, input logic [23:0] d,
                              input logic mv, input logic [7:0] md, input logic ml,
                              input logic mu, input logic [2:0] sr, input logic gv,
                              input logic [2:0] gi, input logic [15:0] fc);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.u = u; r.d = d;
    r.exp = {mv, md, ml, mu, sr, gv, gi, fc};
    return r;
  endfunction

  function automatic logic [33:0] snap();
    return {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_axis_tready,
            grant_valid, grant_index, frame_count};
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic [2:0] u,
                       input logic [23:0] d, input logic rdy);
    s_axis_tvalid = v; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tdata = d; m_axis_tready = rdy;
  endtask

  initial begin
    int beats;
    logic rdy;

    // Three 4-beat frames requested together: served 0,1,2 with an idle cycle between.
    tbl.push_back(mk(0,3'b111,3'b000,3'b000,24'h201000, 0,8'h00,0,0,3'b000,0,3'd0,16'd0));
    tbl.push_back(mk(1,3'b111,3'b000,3'b000,24'h201000, 0,8'h00,0,0,3'b000,0,3'd0,16'd0));
    tbl.push_back(mk(1,3'b111,3'b000,3'b000,24'h201000, 1,8'h00,0,0,3'b001,1,3'd0,16'd0));
    tbl.push_back(mk(1,3'b111,3'b000,3'b000,24'h201001, 1,8'h01,0,0,3'b001,1,3'd0,16'd0));
    tbl.push_back(mk(1,3'b111,3'b000,3'b000,24'h201002, 1,8'h02,0,0,3'b001,1,3'd0,16'd0));
    tbl.push_back(mk(1,3'b111,3'b001,3'b000,24'h201003, 1,8'h03,1,0,3'b001,1,3'd0,16'd0));
    tbl.push_back(mk(1,3'b110,3'b000,3'b000,24'h201000, 0,8'h00,0,0,3'b000,0,3'd0,16'd1));
    tbl.push_back(mk(1,3'b110,3'b000,3'b000,24'h201000, 1,8'h10,0,0,3'b010,1,3'd1,16'd1));
    tbl.push_back(mk(1,3'b110,3'b000,3'b000,24'h201100, 1,8'h11,0,0,3'b010,1,3'd1,16'd1));
    tbl.push_back(mk(1,3'b110,3'b000,3'b000,24'h201200, 1,8'h12,0,0,3'b010,1,3'd1,16'd1));
    tbl.push_back(mk(1,3'b110,3'b010,3'b000,24'h201300, 1,8'h13,1,0,3'b010,1,3'd1,16'd1));
    tbl.push_back(mk(1,3'b100,3'b000,3'b000,24'h200000, 0,8'h00,0,0,3'b000,0,3'd1,16'd2));
    tbl.push_back(mk(1,3'b100,3'b000,3'b000,24'h200000, 1,8'h20,0,0,3'b100,1,3'd2,16'd2));
    tbl.push_back(mk(1,3'b100,3'b000,3'b000,24'h210000, 1,8'h21,0,0,3'b100,1,3'd2,16'd2));
    tbl.push_back(mk(1,3'b100,3'b000,3'b000,24'h220000, 1,8'h22,0,0,3'b100,1,3'd2,16'd2));
    tbl.push_back(mk(1,3'b100,3'b100,3'b000,24'h230000, 1,8'h23,1,0,3'b100,1,3'd2,16'd2));
    tbl.push_back(mk(1,3'b000,3'b000,3'b000,24'h000000, 0,8'h00,0,0,3'b000,0,3'd2,16'd3));
    // Single-beat frame with tuser set, from src0.
    tbl.push_back(mk(1,3'b001,3'b001,3'b001,24'h0000A5, 0,8'h00,0,0,3'b000,0,3'd2,16'd3));
    tbl.push_back(mk(1,3'b001,3'b001,3'b001,24'h0000A5, 1,8'hA5,1,1,3'b001,1,3'd0,16'd3));
    // ptr=1 now: src0 and src2 together -> src2 first, then src0.
    tbl.push_back(mk(1,3'b101,3'b000,3'b000,24'h500030, 0,8'h00,0,0,3'b000,0,3'd0,16'd4));
    tbl.push_back(mk(1,3'b101,3'b000,3'b000,24'h500030, 1,8'h50,0,0,3'b100,1,3'd2,16'd4));
    tbl.push_back(mk(1,3'b101,3'b100,3'b000,24'h510030, 1,8'h51,1,0,3'b100,1,3'd2,16'd4));
    tbl.push_back(mk(1,3'b001,3'b000,3'b000,24'h000030, 0,8'h00,0,0,3'b000,0,3'd2,16'd5));
    tbl.push_back(mk(1,3'b001,3'b000,3'b000,24'h000030, 1,8'h30,0,0,3'b001,1,3'd0,16'd5));
    tbl.push_back(mk(1,3'b001,3'b001,3'b000,24'h000031, 1,8'h31,1,0,3'b001,1,3'd0,16'd5));
    tbl.push_back(mk(1,3'b000,3'b000,3'b000,24'h000000, 0,8'h00,0,0,3'b000,0,3'd0,16'd6));
    // src1 single beat leaves ptr=2, then src0 frame is cut by reset.
    tbl.push_back(mk(1,3'b010,3'b010,3'b000,24'h006000, 0,8'h00,0,0,3'b000,0,3'd0,16'd6));
    tbl.push_back(mk(1,3'b010,3'b010,3'b000,24'h006000, 1,8'h60,1,0,3'b010,1,3'd1,16'd6));
    tbl.push_back(mk(1,3'b001,3'b000,3'b000,24'h000070, 0,8'h00,0,0,3'b000,0,3'd1,16'd7));
    tbl.push_back(mk(1,3'b001,3'b000,3'b000,24'h000070, 1,8'h70,0,0,3'b001,1,3'd0,16'd7));
    tbl.push_back(mk(0,3'b001,3'b000,3'b000,24'h000071, 0,8'h00,0,0,3'b000,0,3'd0,16'd0));
    // After reset the pointer is 0 again: src1 beats src2.
    tbl.push_back(mk(1,3'b110,3'b000,3'b000,24'h908000, 0,8'h00,0,0,3'b000,0,3'd0,16'd0));
    tbl.push_back(mk(1,3'b110,3'b000,3'b000,24'h908000, 1,8'h80,0,0,3'b010,1,3'd1,16'd0));
    tbl.push_back(mk(1,3'b110,3'b010,3'b000,24'h908100, 1,8'h81,1,0,3'b010,1,3'd1,16'd0));
    tbl.push_back(mk(1,3'b000,3'b000,3'b000,24'h000000, 0,8'h00,0,0,3'b000,0,3'd1,16'd1));

    rst_n = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst;
      drive(tbl[i].v, tbl[i].l, tbl[i].u, tbl[i].d, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d", i), snap(), tbl[i].exp);
      n_chk++;
      if (timeout_event === 1'b0) n_pass++;
      else $display("FAIL vec%0d_timeout_event: got %b expected 0", i, timeout_event);
      tick();
    end

    // 10-beat frame from src1 under alternating m_tready (ptr=2, only src1 requests).
    beats = 0;
    rdy   = 1'b1;
    drive(3'b010, 3'b000, 3'b000, 24'h00B000, 1'b1);
    @(negedge clk);
    chk("bp_idle", snap(), {1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd1, 16'd1});
    tick();
    for (int c = 0; c < 40 && beats < 10; c++) begin
      drive(3'b010, (beats == 9) ? 3'b010 : 3'b000, 3'b000,
            {8'h00, 8'hB0 + 8'(beats), 8'h00}, rdy);
      @(negedge clk);
      chk($sformatf("bp_beat%0d_rdy%0d", beats, rdy), snap(),
          {1'b1, 8'hB0 + 8'(beats), (beats == 9), 1'b0, {1'b0, rdy, 1'b0}, 1'b1, 3'd1, 16'd1});
      @(posedge clk);
      if (rdy) beats++;
      rdy = ~rdy;
      #1;
    end
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1);
    @(negedge clk);
    chk("bp_done", snap(), {1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd1, 16'd2});
    chk("bp_beats", 34'(beats), 34'd10);
    tick();

`ifdef ARB_TIMEOUT_EN
    // src0: 3 beats then an 8-cycle stall -> abort beat, then drain of the rest.
    drive(3'b001, 3'b000, 3'b000, 24'h0000C0, 1'b1);
    @(negedge clk);
    chk("to_idle", snap(), {1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd1, 16'd2});
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b001, 3'b000, 3'b000, {16'h0, 8'hC0 + 8'(k)}, 1'b1);
      @(negedge clk);
      chk($sformatf("to_beat%0d", k), snap(),
          {1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0, 3'b001, 1'b1, 3'd0, 16'd2});
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1);
      @(negedge clk);
      chk($sformatf("to_stall%0d", k), {snap(), timeout_event} >> 1,
          {1'b0, 8'h00, 1'b0, 1'b0, 3'b001, 1'b1, 3'd0, 16'd2});
      chk($sformatf("to_stall%0d_ev", k), 34'(timeout_event), 34'd0);
      tick();
    end
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b0);
    @(negedge clk);
    chk("to_abort_hold", snap(), {1'b1, 8'h00, 1'b1, 1'b1, 3'b000, 1'b1, 3'd0, 16'd2});
    chk("to_abort_hold_ev", 34'(timeout_event), 34'd0);
    tick();
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1);
    @(negedge clk);
    chk("to_abort", snap(), {1'b1, 8'h00, 1'b1, 1'b1, 3'b000, 1'b1, 3'd0, 16'd2});
    chk("to_abort_ev", 34'(timeout_event), 34'd1);
    tick();
    drive(3'b001, 3'b000, 3'b000, 24'h0000C3, 1'b1);
    @(negedge clk);
    chk("to_drop0", snap(), {1'b0, 8'h00, 1'b0, 1'b0, 3'b001, 1'b1, 3'd0, 16'd3});
    chk("to_drop0_ev", 34'(timeout_event), 34'd0);
    tick();
    drive(3'b001, 3'b001, 3'b000, 24'h0000C4, 1'b1);
    @(negedge clk);
    chk("to_drop1", snap(), {1'b0, 8'h00, 1'b0, 1'b0, 3'b001, 1'b1, 3'd0, 16'd3});
    tick();
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1);
    @(negedge clk);
    chk("to_end", snap(), {1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 16'd3});
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
